tx_frame_controller: RTL and testbench
======================================

# tx_frame_controller

Sequences one Ethernet frame at a time onto the MAC transmit AXI-Stream port: 14 header bytes built from latched address/length fields, then the payload popped from the TX byte buffer, then zero padding up to the 46-byte minimum payload. It is the transmit-side counterpart of the receive controller. It sits between the pattern generator, which writes the TX buffer and pulses `tx_start`, and the tri-mode MAC `tx_axis_*` slave.

## Interface
- `MIN_PAYLOAD`, 46: minimum payload bytes; shorter frames are zero-padded to this length.
- `MAX_PAYLOAD`, 1500: largest legal `payload_len`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `tx_start` input 1: frame request; sampled only in IDLE.
- `dst_mac` input 48: destination address; latched on an accepted start.
- `src_mac` input 48: source address; latched on an accepted start.
- `payload_len` input 11: payload byte count; latched on an accepted start and sent as the length/type field.
- `btx_data` input 8: head byte of the TX buffer (first-word-fall-through, valid whenever `!btx_empty`).
- `btx_empty` input 1: TX buffer empty.
- `btx_rd_en` output 1: pops the TX buffer head.
- `tx_axis_tdata` output 8: stream byte to the MAC.
- `tx_axis_tvalid` output 1: byte valid.
- `tx_axis_tlast` output 1: final byte of the frame.
- `tx_axis_tready` input 1: MAC accepts the byte.
- `tx_busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse after the final beat is accepted.
- `tx_err` output 1: one-cycle pulse when a start is rejected for an illegal length.

## Operation
- **States:** IDLE, HDR, PAYLOAD, PAD, DONE.
- **beat:** a cycle with `tx_axis_tvalid & tx_axis_tready`. All counters and state transitions advance only on beats, except the IDLE and DONE transitions below.
- **IDLE, legal start:** `tx_start=1` with 1 ≤ `payload_len` ≤ `MAX_PAYLOAD` latches `dst_mac`, `src_mac` and `payload_len`, clears all counters and moves to HDR.
- **IDLE, illegal start:** `tx_start=1` with any other `payload_len` pulses `tx_err` on the next cycle and stays in IDLE.
- **HDR:** `tvalid=1`. `hdr_cnt` (4 bits) runs 0..13 and selects the byte:
  - bytes 0–5: `dst_mac[47:40]` down to `dst_mac[7:0]`;
  - bytes 6–11: `src_mac`, same MSB-first order;
  - byte 12: `{5'b0, len[10:8]}`;
  - byte 13: `len[7:0]`.
  - The beat at `hdr_cnt=13` moves to PAYLOAD.
- **PAYLOAD:**
  - `tdata=btx_data`, `tvalid=!btx_empty`, `btx_rd_en = tvalid & tready`.
  - `pay_cnt` (11 bits) counts beats.
  - Beat with `pay_cnt = len-1` moves to PAD if `len < MIN_PAYLOAD`, otherwise to DONE.
- **PAD:** `tdata=8'h00`, `tvalid=1`. `pad_cnt` (6 bits) counts from `len` up to `MIN_PAYLOAD-1`; the last beat moves to DONE.
- **tlast:** asserted together with `tvalid` on exactly one beat, the final payload byte or the final pad byte.
- **DONE:** `tx_done=1` and all stream outputs low for one cycle, then unconditionally back to IDLE.
- **Frame length:** a frame is always exactly 14 + max(`len`, 46) beats. `btx_rd_en` pulses exactly `len` times per frame and never in HDR, PAD or DONE.
- **Starts while busy:** `tx_start` in any state other than IDLE is ignored and not queued.
- **Buffer empty mid-payload:** `tvalid` drops and no pop occurs. Transmission resumes on the byte at the head when `btx_empty` falls. The pattern generator must prefill the buffer if gap-free frames are required.
- **Output stability:** `tdata` and `tlast` are held stable while `tvalid=1` and `tready=0`.

## Timing
- **Reset:**
  - With `rst_n=0` at an edge, on the following cycle: state IDLE, all counters 0, and `tx_axis_tdata=0`, `tx_axis_tvalid=0`, `tx_axis_tlast=0`, `btx_rd_en=0`, `tx_busy=0`, `tx_done=0`, `tx_err=0`.
  - Reset mid-frame abandons the frame with no `tlast`, no `tx_done` and no further pops.
- **Start latency:** `tx_start` high at edge N in IDLE gives `tvalid=1` with `dst_mac[47:40]` from cycle N+1.
- **Throughput:** with `tready=1` and the buffer never empty, one byte per cycle. The last beat is at cycle N+14+max(len,46), `tx_done` is high in the following cycle, and IDLE follows.
- **Next start:** the earliest accepted next start is sampled 2 cycles after the last beat.
- **Output paths:**
  - `btx_rd_en` and PAYLOAD `tdata`/`tvalid` are combinational from state, `btx_empty` and `tready`.
  - `tx_done`, `tx_err` and `tx_busy` are registered.
- **len = 46:** no PAD state is entered; `tlast` is on payload byte 45.

## Test plan
- **Basic frame:** `len=64`, buffer prefilled with 0x00..0x3F, `tready=1`, dst=0x0A0B0C0D0E0F, src=0x112233445566 → 78 beats; beats 12–13 are 0x00, 0x40; payload matches the buffer; `tlast` on beat 78; `tx_done` one cycle later; 64 pops.
- **Padded frame:** `len=10` → 10 buffer bytes then 36 bytes of 0x00, 60 beats total, `tlast` on beat 60, exactly 10 `btx_rd_en` pulses.
- **Backpressure:** `tready` toggling with a random 50% duty, `len=46` → byte sequence identical to the `tready=1` run, `tdata` stable across stalls, no pop while `tready=0`.
- **Underrun:** buffer runs empty after 20 of 50 bytes for 5 cycles → `tvalid=0` and `btx_rd_en=0` for those cycles, then bytes 20..49 follow in order.
- **Illegal length:** `len=0` and `len=1501` → `tx_err` pulse, `tvalid` stays 0, `tx_busy` stays 0. A second `tx_start` during a legal frame is ignored.
- **Reset mid-frame:** `rst_n=0` during PAYLOAD beat 5 → all outputs 0 the next cycle, no `tx_done`; a new legal start afterwards produces a correct full frame.

Source files
------------

// File: rtl/tx_frame_controller.sv
// Ethernet transmit sequencer: streams a 14-byte header, the buffered payload,
// then zero padding up to the minimum payload size onto an AXI-Stream byte port.
module tx_frame_controller #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [10:0] payload_len,
  input  logic [7:0]  btx_data,
  input  logic        btx_empty,
  output logic        btx_rd_en,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err
);

  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [5:0]  PAD_LAST = 6'(MIN_PAYLOAD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] dst_q, src_q;
  logic [10:0] len_q;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [5:0]  pad_cnt_q, pad_cnt_d;
  logic        busy_q, done_q, err_q, err_d;
  logic        start_ok, short_frame, last_pay;
  logic [7:0]  hdr_bytes [16];

  assign start_ok    = tx_start && (payload_len != 11'd0) && (payload_len <= MAX_LEN);
  assign short_frame = len_q < MIN_LEN;
  assign last_pay    = pay_cnt_q == (len_q - 11'd1);

  // Header byte table, addressed directly by hdr_cnt (entries 14/15 never selected).
  for (genvar gi = 0; gi < 6; gi++) begin : g_mac_bytes
    assign hdr_bytes[gi]     = dst_q[47-8*gi -: 8];
    assign hdr_bytes[gi + 6] = src_q[47-8*gi -: 8];
  end
  assign hdr_bytes[12] = {5'b0, len_q[10:8]};
  assign hdr_bytes[13] = len_q[7:0];
  assign hdr_bytes[14] = 8'h00;
  assign hdr_bytes[15] = 8'h00;

  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    pay_cnt_d      = pay_cnt_q;
    pad_cnt_d      = pad_cnt_q;
    err_d          = 1'b0;
    tx_axis_tdata  = 8'h00;
    tx_axis_tvalid = 1'b0;
    tx_axis_tlast  = 1'b0;
    btx_rd_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_HDR;
          hdr_cnt_d = 4'd0;
          pay_cnt_d = 11'd0;
          pad_cnt_d = 6'd0;
        end else if (tx_start) begin
          err_d = 1'b1;
        end
      end
      S_HDR: begin
        tx_axis_tdata  = hdr_bytes[hdr_cnt_q];
        tx_axis_tvalid = 1'b1;
        if (tx_axis_tready) begin
          if (hdr_cnt_q == 4'd13) state_d = S_PAYLOAD;
          else                    hdr_cnt_d = hdr_cnt_q + 4'd1;
        end
      end
      S_PAYLOAD: begin
        // The FWFT head byte only changes on a pop, so it is stable through stalls.
        tx_axis_tdata  = btx_data;
        tx_axis_tvalid = !btx_empty;
        tx_axis_tlast  = !btx_empty && last_pay && !short_frame;
        btx_rd_en      = !btx_empty && tx_axis_tready;
        if (btx_rd_en) begin
          pay_cnt_d = pay_cnt_q + 11'd1;
          if (last_pay) begin
            if (short_frame) begin
              state_d   = S_PAD;
              pad_cnt_d = len_q[5:0];
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_PAD: begin
        tx_axis_tvalid = 1'b1;
        tx_axis_tlast  = pad_cnt_q == PAD_LAST;
        if (tx_axis_tready) begin
          if (pad_cnt_q == PAD_LAST) state_d = S_DONE;
          else                       pad_cnt_d = pad_cnt_q + 6'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dst_q     <= '0;
      src_q     <= '0;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      pad_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      busy_q    <= state_d != S_IDLE;
      done_q    <= state_d == S_DONE;
      err_q     <= err_d;
      if (state_q == S_IDLE && start_ok) begin
        dst_q <= dst_mac;
        src_q <= src_mac;
        len_q <= payload_len;
      end
    end
  end

  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed/randomised bench for tx_frame_controller; each frame is checked
// against a byte-list model built from the frame format rules.
module tb_tx_frame_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [10:0] payload_len = '0;
  logic [7:0]  btx_data;
  logic        btx_empty;
  logic        btx_rd_en;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tvalid;
  logic        tx_axis_tlast;
  logic        tx_axis_tready = 1'b1;
  logic        tx_busy, tx_done, tx_err;

  tx_frame_controller #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .dst_mac(dst_mac),
    .src_mac(src_mac), .payload_len(payload_len), .btx_data(btx_data),
    .btx_empty(btx_empty), .btx_rd_en(btx_rd_en), .tx_axis_tdata(tx_axis_tdata),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // TX buffer model: bytes below 'limit' are visible to the DUT
  logic [7:0]  bmem [4096];
  logic [11:0] rd_ptr = '0, wr_ptr = '0, limit = '0;
  assign btx_data  = bmem[rd_ptr];
  assign btx_empty = (rd_ptr == limit);

  int n_total = 0, n_pass = 0, cyc = 0;
  logic [7:0] got_data [$];
  bit         got_last [$];
  int  pops, frame_len, ur_seen;
  bit  pop_pending = 0, in_frame = 0, bp_mode = 0, ur_active = 0;
  bit  prev_v = 0, prev_r = 0, prev_l = 0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    int idx;
    bit beat;
    @(posedge clk); #1;
    cyc++;
    if (pop_pending) rd_ptr++;
    pop_pending = 0;
    if (ur_active && ur_seen == 5) begin
      limit = wr_ptr;
      ur_active = 0;
    end
    tx_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    beat = tx_axis_tvalid && tx_axis_tready;
    if (in_frame) begin
      if (prev_v && !prev_r) begin
        chk("stall_valid", tx_axis_tvalid, 1);
        chk("stall_data", tx_axis_tdata, prev_d);
        chk("stall_last", tx_axis_tlast, prev_l);
      end
      idx = got_data.size();
      chk($sformatf("rd_en@%0d", idx), btx_rd_en, beat && idx >= 14 && idx < 14 + frame_len);
      if (!tx_axis_tvalid) chk("tlast_no_valid", tx_axis_tlast, 0);
      if (ur_active && rd_ptr == limit) begin
        chk("underrun_valid", tx_axis_tvalid, 0);
        ur_seen++;
      end
      if (beat) begin
        got_data.push_back(tx_axis_tdata);
        got_last.push_back(tx_axis_tlast);
      end
    end
    if (btx_rd_en) begin
      pops++;
      pop_pending = 1;
    end
    prev_v = tx_axis_tvalid;
    prev_r = tx_axis_tready;
    prev_d = tx_axis_tdata;
    prev_l = tx_axis_tlast;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tvalid"}, tx_axis_tvalid, 0);
    chk({tag, "_tlast"}, tx_axis_tlast, 0);
    chk({tag, "_tdata"}, tx_axis_tdata, 0);
    chk({tag, "_rd_en"}, btx_rd_en, 0);
    chk({tag, "_busy"}, tx_busy, 0);
    chk({tag, "_done"}, tx_done, 0);
    chk({tag, "_err"}, tx_err, 0);
  endtask

  // One frame: model bytes = dst, src, length, buffer contents, zero padding.
  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input int len,
                           input bit pattern, input bit bp, input bit ur,
                           input bit extra_start, input int rst_beat);
    logic [7:0]  exp [$];
    logic [11:0] base;
    logic [10:0] l11;
    int nbeats, c0, cdone, n;
    bit done_seen, extra_done;
    l11 = 11'(len);
    base = rd_ptr;
    for (int i = 0; i < len; i++) begin
      bmem[wr_ptr] = pattern ? 8'(i) : 8'($urandom);
      wr_ptr++;
    end
    limit = ur ? 12'(base + 12'd20) : wr_ptr;
    ur_active = ur;
    ur_seen = 0;
    nbeats = 14 + ((len < 46) ? 46 : len);
    for (int i = 0; i < 6; i++) exp.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp.push_back(s[47-8*i -: 8]);
    exp.push_back({5'b0, l11[10:8]});
    exp.push_back(l11[7:0]);
    for (int i = 0; i < len; i++) exp.push_back(bmem[12'(base + 12'(i))]);
    while (exp.size() < nbeats) exp.push_back(8'h00);

    got_data.delete();
    got_last.delete();
    pops = 0;
    frame_len = len;
    bp_mode = bp;
    prev_v = 0;
    in_frame = 1;
    dst_mac = d;
    src_mac = s;
    payload_len = l11;
    tx_start = 1;
    cycle();
    tx_start = 0;
    c0 = cyc;
    chk("start_valid", tx_axis_tvalid, 1);
    chk("start_data", tx_axis_tdata, d[47:40]);
    done_seen = 0;
    extra_done = 0;
    n = 0;
    while (!done_seen && n < 8000) begin
      if (extra_start && !extra_done && got_data.size() >= 20) begin
        tx_start = 1;
        payload_len = 11'd7;
        dst_mac = ~d;
        extra_done = 1;
      end
      if (rst_beat >= 0 && got_data.size() == 14 + rst_beat + 1) begin
        in_frame = 0;
        rst_n = 0;
        cycle();
        chk_quiet("rst_mid");
        rst_n = 1;
        cycle();
        chk_quiet("rst_after");
        limit = wr_ptr;
        rd_ptr = wr_ptr;
        pop_pending = 0;
        ur_active = 0;
        bp_mode = 0;
        return;
      end
      cycle();
      tx_start = 0;
      n++;
      if (tx_done) begin
        done_seen = 1;
        cdone = cyc;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("done_stream_quiet", {tx_axis_tvalid, tx_axis_tlast, btx_rd_en}, 0);
    chk("done_busy", tx_busy, 1);
    chk("beats", got_data.size(), nbeats);
    for (int i = 0; i < got_data.size() && i < nbeats; i++) begin
      chk($sformatf("byte%0d", i), got_data[i], exp[i]);
      chk($sformatf("tlast%0d", i), got_last[i], i == nbeats - 1);
    end
    chk("pops", pops, len);
    if (ur) chk("underrun_cycles", ur_seen, 5);
    if (!bp && !ur && done_seen) chk("latency", cdone - c0, nbeats);
    in_frame = 0;
    bp_mode = 0;
    cycle();
    chk("post_done", tx_done, 0);
    chk("post_busy", tx_busy, 0);
    if (extra_start) begin
      cycle();
      chk("ignored_start_busy", tx_busy, 0);
    end
  endtask

  task automatic illegal(input logic [10:0] len);
    payload_len = len;
    tx_start = 1;
    cycle();
    tx_start = 0;
    chk($sformatf("err_pulse_len%0d", len), tx_err, 1);
    chk("err_tvalid", tx_axis_tvalid, 0);
    chk("err_busy", tx_busy, 0);
    cycle();
    chk("err_clear", tx_err, 0);
    chk("err_tvalid2", tx_axis_tvalid, 0);
    chk("err_busy2", tx_busy, 0);
  endtask

  initial begin
    rst_n = 0;
    cycle();
    cycle();
    chk_quiet("reset");
    rst_n = 1;
    cycle();
    chk_quiet("idle");

    run_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 64, 1, 0, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 10, 0, 0, 0, 0, -1);
    run_frame(48'h0102030405AA, 48'h665544332211, 46, 1, 0, 0, 0, -1);
    run_frame(48'h0102030405AA, 48'h665544332211, 46, 1, 1, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 50, 0, 0, 1, 0, -1);
    illegal(11'd0);
    illegal(11'd1501);
    illegal(11'd2047);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 100, 0, 0, 0, 1, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 50, 0, 0, 0, 0, 5);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 30, 0, 1, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1, 0, 0, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 45, 0, 1, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 47, 0, 0, 0, 0, -1);
    run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1500, 0, 0, 0, 0, -1);
    for (int k = 0; k < 3; k++)
      run_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                int'($urandom_range(1, 120)), 0, 1, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
